ppu_apu_multiport_adapter: RTL
==============================

Name: ppu_apu_multiport_adapter

Overview:
- Multi-channel successor to the single-port posit APU wrapper.
- Arbitrates NUM_PORTS core-side APU request channels onto one posit unit (PPU) interface.
- Tags each issued operation with its port index and buffers returned results in a tagged response FIFO.
- Credit-based granting guarantees FIFO space for every in-flight operation, so the PPU output is never back-pressured. Per-port result back-pressure is supported.

Parameters:
NUM_PORTS, 2, number of requesting APU channels (1..8)
NARGS, 3, operands per request
WOP, 6, op field width ({vec_op, op_mod, op})
NDSFLAGS, 15, downstream flag width ({int_fmt, src_fmt, dst_fmt, rnd_mode})
NUSFLAGS, 5, upstream status width
DEPTH, 4, response FIFO depth = max operations reserved (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  NUM_PORTS  per-port request valid
gnt_o  out  NUM_PORTS  per-port grant (one-hot or zero)
operands_i  in  NUM_PORTS*NARGS*32  per-port operands
op_i  in  NUM_PORTS*WOP  per-port op
flags_i  in  NUM_PORTS*NDSFLAGS  per-port flags
rvalid_o  out  NUM_PORTS  per-port result valid
rready_i  in  NUM_PORTS  per-port result ready
rdata_o  out  32  result data (shared, qualified by rvalid_o)
rflags_o  out  NUSFLAGS  result status (shared)
ppu_valid_o  out  1  issue valid to PPU
ppu_ready_i  in  1  PPU in_ready
ppu_operands_o  out  NARGS*32  issued operands
ppu_op_o  out  WOP  issued op
ppu_flags_o  out  NDSFLAGS  issued flags
ppu_tag_o  out  TAG_W  issued tag = port index; TAG_W = max(1, clog2(NUM_PORTS))
ppu_valid_i  in  1  PPU out_valid
ppu_result_i  in  32  PPU result
ppu_status_i  in  NUSFLAGS  PPU status
ppu_tag_i  in  TAG_W  returned tag
ppu_ready_o  out  1  PPU out_ready, constant 1 after reset

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs 0 except ppu_ready_o = 1.
  - Issue register empty; RR pointer = 0; credit counter cnt = 0; FIFO empty.
  - Reset mid-operation discards in-flight results. Any ppu_valid_i in the reset cycle is ignored.
- Issue register (1 entry: operands, op, flags, tag); ppu_valid_o = issue_full.
- Capture condition: any req_i, AND cnt < DEPTH, AND (issue register empty OR ppu_ready_i high this cycle).
- Arbitration: round-robin starting at the RR pointer.
  - gnt_o[w] is asserted combinationally in the capture cycle t. The winner's fields are loaded; ppu_valid_o goes high at t+1.
  - The RR pointer moves to (w+1) mod NUM_PORTS on capture only.
- Issue register clears on ppu_valid_o && ppu_ready_i, unless a new capture occurs in the same cycle (back-to-back allowed).
- Issued fields stay stable while ppu_valid_o is high and ppu_ready_i is low.
- Credits:
  - cnt increments on capture and decrements on FIFO pop.
  - Simultaneous capture and pop leaves cnt unchanged.
  - cnt never exceeds DEPTH; at cnt == DEPTH no grant is given, even if a pop occurs that cycle.
- Response FIFO:
  - ppu_valid_i pushes {result, status, tag}. A push when full is impossible by construction; it is flagged by an assertion and the data is dropped.
  - Registered, no fall-through: data pushed at cycle u is visible at u+1.
  - rvalid_o[p] = !empty && head.tag == p. rdata_o/rflags_o = head fields, 0 when empty.
  - Pop on rvalid_o[head.tag] && rready_i[head.tag].
  - Push and pop in the same cycle are allowed at any occupancy below full.
  - Head-of-line blocking across ports is intended; results return in PPU completion order.
- Read/write pointers are clog2(DEPTH) bits and wrap naturally; an occupancy counter distinguishes full from empty.
- A tag >= NUM_PORTS returned by the PPU is an assertion failure. The entry is still popped when rready_i[0] is high, so it cannot deadlock.

Optional Feature:
PPU_ADAPTER_STICKY_FLAGS_EN:
- When defined:
  - Adds input flags_clr_i [NUM_PORTS] and output sticky_flags_o [NUM_PORTS*NUSFLAGS].
  - On each pop, the head status is ORed into the sticky register of the head tag.
  - flags_clr_i[p] clears port p's register. Clear has priority over an OR in the same cycle.
  - Registers reset to 0.
- When undefined: these ports and registers do not exist.

Decomposition:
- Package ppu_adapter_pkg:
  - default parameter constants;
  - tag width function;
  - typedef resp_entry_t {result, status, tag};
  - typedef issue_entry_t {operands, op, flags, tag}.
- One sub-module, ppu_adapter_resp_fifo: parametrised DEPTH and entry type; push/pop/full/empty/occupancy; synchronous active-high reset.
- Round-robin arbitration stays inline.

Test Plan:
1. Single request: req_i = 01, ppu_ready_i = 1, operands 0x40000000/0x40000000 → gnt_o = 01 same cycle, ppu_valid_o at t+1 with tag 0. PPU returns 0x48000000 tag 0 at u → rvalid_o = 01, rdata_o = 0x48000000 at u+1.
2. Contention: req_i = 11 held continuously, PPU always ready and returning 2 cycles later, rready_i = 11 → grants alternate 01, 10, 01, 10; cnt stays ≤ DEPTH.
3. Credit exhaustion: DEPTH = 4, rready_i = 00, 6 requests → exactly 4 grants, then gnt_o = 0. Raise rready_i[0] with head tag 0 → one pop, one new grant the following cycle.
4. PPU stall: ppu_ready_i = 0 for 5 cycles with ppu_valid_o high → ppu_operands_o/tag stable; no further grants.
5. Reset mid-flight: 3 operations outstanding, assert rst_i → the next cycle has all rvalid_o = 0, cnt = 0, RR pointer = 0, and a new request is granted normally.
6. With the macro defined: pop with status 5'b00001, then 5'b10000, on port 1 → sticky_flags_o port 1 = 5'b10001. flags_clr_i[1] coinciding with a pop → 0.

Source files
------------

// File: rtl/ppu_adapter_pkg.sv
// Shared constants and entry types for the multi-port posit APU adapter.
package ppu_adapter_pkg;

    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_NARGS     = 3;
    localparam int DEF_WOP       = 6;
    localparam int DEF_NDSFLAGS  = 15;
    localparam int DEF_NUSFLAGS  = 5;
    localparam int DEF_DEPTH     = 4;

    // A single port still needs one tag bit so the tag field never collapses.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_TAG_W = tag_width(DEF_NUM_PORTS);

    typedef struct packed {
        logic [31:0]              result;
        logic [DEF_NUSFLAGS-1:0]  status;
        logic [DEF_TAG_W-1:0]     tag;
    } resp_entry_t;

    typedef struct packed {
        logic [DEF_NARGS*32-1:0]  operands;
        logic [DEF_WOP-1:0]       op;
        logic [DEF_NDSFLAGS-1:0]  flags;
        logic [DEF_TAG_W-1:0]     tag;
    } issue_entry_t;

endpackage

// File: rtl/ppu_adapter_resp_fifo.sv
// Tagged response FIFO: registered storage, no fall-through, occupancy-based full/empty.
module ppu_adapter_resp_fifo
    import ppu_adapter_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = resp_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (occ_reg == OCC_W'(DEPTH));
    assign empty     = (occ_reg == '0);
    assign occupancy = occ_reg;
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head      = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/ppu_apu_multiport_adapter.sv
// Round-robin, credit-gated arbitration of NUM_PORTS APU channels onto one PPU.
// Optional sticky per-port status registers: define PPU_ADAPTER_STICKY_FLAGS_EN.
module ppu_apu_multiport_adapter
    import ppu_adapter_pkg::*;
#(
    parameter int  NUM_PORTS = DEF_NUM_PORTS,
    parameter int  NARGS     = DEF_NARGS,
    parameter int  WOP       = DEF_WOP,
    parameter int  NDSFLAGS  = DEF_NDSFLAGS,
    parameter int  NUSFLAGS  = DEF_NUSFLAGS,
    parameter int  DEPTH     = DEF_DEPTH,
    localparam int TAG_W     = tag_width(NUM_PORTS)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    input  logic [NUM_PORTS*NARGS*32-1:0]   operands_i,
    input  logic [NUM_PORTS*WOP-1:0]        op_i,
    input  logic [NUM_PORTS*NDSFLAGS-1:0]   flags_i,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    input  logic [NUM_PORTS-1:0]            rready_i,
    output logic [31:0]                     rdata_o,
    output logic [NUSFLAGS-1:0]             rflags_o,
    output logic                            ppu_valid_o,
    input  logic                            ppu_ready_i,
    output logic [NARGS*32-1:0]             ppu_operands_o,
    output logic [WOP-1:0]                  ppu_op_o,
    output logic [NDSFLAGS-1:0]             ppu_flags_o,
    output logic [TAG_W-1:0]                ppu_tag_o,
    input  logic                            ppu_valid_i,
    input  logic [31:0]                     ppu_result_i,
    input  logic [NUSFLAGS-1:0]             ppu_status_i,
    input  logic [TAG_W-1:0]                ppu_tag_i,
    output logic                            ppu_ready_o
`ifdef PPU_ADAPTER_STICKY_FLAGS_EN
    ,
    input  logic [NUM_PORTS-1:0]            flags_clr_i,
    output logic [NUM_PORTS*NUSFLAGS-1:0]   sticky_flags_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]          result;
        logic [NUSFLAGS-1:0]  status;
        logic [TAG_W-1:0]     tag;
    } resp_t;

    typedef struct packed {
        logic [NARGS*32-1:0]  operands;
        logic [WOP-1:0]       op;
        logic [NDSFLAGS-1:0]  flags;
        logic [TAG_W-1:0]     tag;
    } issue_t;

    logic [TAG_W-1:0] rr_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             issue_full_reg;
    issue_t           issue_reg;
    issue_t           win_entry;
    logic             win_found;
    logic [TAG_W-1:0] win_idx;
    logic [TAG_W-1:0] cand;
    logic             capture;
    logic             pop;
    logic             pop_ready;
    resp_t            push_entry;
    resp_t            head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_occ;

    // First requester at or after the round-robin pointer wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = TAG_W'((int'(rr_ptr_reg) + k) % NUM_PORTS);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_entry.operands = operands_i[int'(win_idx)*NARGS*32 +: NARGS*32];
        win_entry.op       = op_i[int'(win_idx)*WOP +: WOP];
        win_entry.flags    = flags_i[int'(win_idx)*NDSFLAGS +: NDSFLAGS];
        win_entry.tag      = win_idx;
    end

    // A credit is taken at capture, so a FIFO slot exists for every issued op.
    assign capture = !rst_i && win_found && (cnt_reg < CNT_W'(DEPTH))
                     && (!issue_full_reg || ppu_ready_i);
    assign gnt_o   = capture ? (NUM_PORTS'(1) << win_idx) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg     <= '0;
            issue_full_reg <= 1'b0;
            issue_reg      <= '0;
        end else if (capture) begin
            rr_ptr_reg     <= (int'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + TAG_W'(1);
            issue_full_reg <= 1'b1;
            issue_reg      <= win_entry;
        end else if (issue_full_reg && ppu_ready_i) begin
            issue_full_reg <= 1'b0;
        end
    end

    assign ppu_valid_o    = issue_full_reg;
    assign ppu_operands_o = issue_reg.operands;
    assign ppu_op_o       = issue_reg.op;
    assign ppu_flags_o    = issue_reg.flags;
    assign ppu_tag_o      = issue_reg.tag;
    assign ppu_ready_o    = 1'b1;

    // Out-of-range tags are released through port 0's ready.
    always_comb begin
        pop_ready = rready_i[0];
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (head.tag == TAG_W'(p)) begin
                pop_ready = rready_i[p];
            end
        end
    end

    assign pop = !fifo_empty && pop_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            case ({capture, pop})
                2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
                2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    assign push_entry.result = ppu_result_i;
    assign push_entry.status = ppu_status_i;
    assign push_entry.tag    = ppu_tag_i;

    ppu_adapter_resp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (resp_t)
    ) u_resp_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (ppu_valid_i && !rst_i),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rvalid
            assign rvalid_o[gi] = !fifo_empty && (head.tag == TAG_W'(gi));
        end
    endgenerate

    assign rdata_o  = fifo_empty ? '0 : head.result;
    assign rflags_o = fifo_empty ? '0 : head.status;

`ifdef PPU_ADAPTER_STICKY_FLAGS_EN
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_sticky
            logic [NUSFLAGS-1:0] sticky_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i || flags_clr_i[gi]) begin
                    sticky_reg <= '0;
                end else if (pop && head.tag == TAG_W'(gi)) begin
                    sticky_reg <= sticky_reg | head.status;
                end
            end
            assign sticky_flags_o[gi*NUSFLAGS +: NUSFLAGS] = sticky_reg;
        end
    endgenerate
`endif

    a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
        !(ppu_valid_i && fifo_full));
    a_tag_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
        !(ppu_valid_i && ({1'b0, ppu_tag_i} >= (TAG_W + 1)'(NUM_PORTS))));
    a_occ_within_credits : assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_occ <= cnt_reg);

endmodule
